transpose_ctrl: RTL and testbench
=================================

Name: transpose_ctrl

Overview:
Streaming controller that drives a single-port RAM to perform in-place N x N matrix transpose with no second buffer. Input tiles arrive row-major. Consecutive tiles are written in alternating row-major and column-major address order. The RAM returns the old word at each written address, so the output stream is the transpose of the previous tile, row-major. The block sits between the upstream element producer and the RAM and consumes the RAM's registered read data.

Parameters:
DATA_WIDTH, 8, element width in bits
DIM_LOG2, 3, log2 of matrix dimension N (N = 2**DIM_LOG2)
ADDR_WIDTH (localparam), 2*DIM_LOG2, RAM address width; N*N words

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  DATA_WIDTH  input element, row-major within a tile
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
flush  input  1  request drain of the stored tile
out_data  output  DATA_WIDTH  transposed element, wired directly from ram_q
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  final element of an output tile
ram_data  output  DATA_WIDTH  RAM write data
ram_addr  output  ADDR_WIDTH  RAM address
ram_we  output  1  RAM write enable; the RAM updates q only when we=1
ram_q  input  DATA_WIDTH  RAM registered output: old contents of ram_addr, one cycle after we

Behaviour:
- Reset (async): row=0, col=0, phase=0, state=EMPTY, out_valid=0, out_last=0. RAM contents are not cleared.
- States:
  - EMPTY: no complete tile stored.
  - STREAM: at least one tile stored.
  - FLUSH: draining the stored tile.
- in_ready = (state != FLUSH) and (!out_valid or out_ready), combinational.
- fire = in_valid and in_ready in EMPTY or STREAM.
- In FLUSH, an internal beat fires whenever (!out_valid or out_ready).
- On a beat:
  - ram_we = 1.
  - ram_data = in_data (0 in FLUSH).
  - ram_addr = {row,col} when phase=0, {col,row} when phase=1.
  - ram_we = 0 on all other cycles. ram_addr and ram_data are don't-care when ram_we = 0.
- Counters: col increments per beat. On col wrap, row increments. On row and col both wrapping (tile end), phase toggles and:
  - EMPTY -> STREAM
  - FLUSH -> EMPTY
  - STREAM -> STREAM
- out_valid:
  - Set the cycle after a beat that fired in STREAM or FLUSH.
  - Not set for beats fired in EMPTY.
  - Cleared when out_ready=1 and no new qualifying beat fired.
  - Held otherwise. ram_q is stable while held because ram_we=0.
- out_last is registered together with out_valid. It is high for the beat where row=col=N-1.
- Latency: one cycle from beat to out_valid. One tile (N*N beats) from an input element to its transposed output.
- Output ordering: output beat k of tile t+1's write period equals element T_t[c][r], where (r,c) is beat k's row-major position.
- flush:
  - Sampled only in STREAM with row=col=0 (tile boundary). Enters FLUSH the next cycle.
  - Ignored in EMPTY, in FLUSH, or mid-tile.
  - flush and fire in the same cycle: the input beat fires, and flush is ignored because the boundary is no longer held.
- Backpressure: with out_valid=1 and out_ready=0, no beat fires. Counters, phase and state are frozen.
- Reset mid-tile or mid-FLUSH: returns to EMPTY. Partial tile discarded. No spurious out_valid after release.

Test Plan:
- N=4, DATA_WIDTH=8: tile A with A[r][c]=16r+c, then tile B all zeros, out_ready=1 -> no out_valid during A. During B, 16 outputs 0x00,0x10,0x20,0x30,0x01,0x11,... (A transposed). out_last only on the 16th output, value 0x33.
- Three back-to-back tiles A, B, C with distinct values -> ram_addr order is row-major, then column-major, then row-major. Outputs are A^T during B and B^T during C. No bubble between tiles.
- After tile A, pulse flush at the boundary -> in_ready=0 for 16 beats, ram_data=0, output stream equals A^T with out_last on the last beat. State returns to EMPTY; the next tile produces no output.
- Hold out_ready=0 for 5 cycles mid-tile with in_valid=1 -> in_ready=0, ram_we=0, out_data and out_valid stable. On release the stream resumes with no loss or duplication.
- Assert reset for 1 cycle after 7 beats of tile B -> out_valid=0 immediately. Then a fresh tile produces no output, and the tile after it outputs the fresh tile's transpose.
- flush pulsed mid-tile and in EMPTY -> ignored: state unchanged and in_ready unaffected.

Source files
------------

// File: rtl/transpose_ctrl.sv
// In-place N x N matrix transpose controller for a single-port read-before-write RAM.
// Alternate tiles are written row-major / column-major; the displaced words form the transposed stream.
module transpose_ctrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DIM_LOG2   = 3,
    localparam int ADDR_WIDTH = 2 * DIM_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [DIM_LOG2-1:0] CNT_MAX = '1;

    logic [DIM_LOG2-1:0] row_q, row_d;
    logic [DIM_LOG2-1:0] col_q, col_d;
    logic                phase_q, phase_d;
    logic [1:0]          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    logic can_advance;
    logic beat;
    logic row_last;
    logic col_last;
    logic tile_end;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        can_advance = !out_valid_q || out_ready;
        in_ready    = (state_q != ST_FLUSH) && can_advance;
        beat        = (state_q == ST_FLUSH) ? can_advance : (in_valid && in_ready);
        row_last    = (row_q == CNT_MAX);
        col_last    = (col_q == CNT_MAX);
        tile_end    = beat && row_last && col_last;

        row_d       = row_q;
        col_d       = col_q;
        phase_d     = phase_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (beat) begin
            col_d = col_q + 1'b1;
            if (col_last) begin
                row_d = row_q + 1'b1;
            end
            if (tile_end) begin
                phase_d = ~phase_q;
                case (state_q)
                    ST_EMPTY:  state_d = ST_STREAM;
                    ST_STREAM: state_d = ST_STREAM;
                    ST_FLUSH:  state_d = ST_EMPTY;
                    default:   state_d = ST_EMPTY;
                endcase
            end
        end else if (flush && state_q == ST_STREAM && row_q == '0 && col_q == '0) begin
            // A drain may only start on a tile boundary, and only when no input beat took it.
            state_d = ST_FLUSH;
        end

        // Words displaced by the first tile after EMPTY are stale and never presented.
        if (beat && (state_q == ST_STREAM || state_q == ST_FLUSH)) begin
            out_valid_d = 1'b1;
            out_last_d  = row_last && col_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (state_q != ST_EMPTY && state_q != ST_STREAM && state_q != ST_FLUSH) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        ram_we   = beat;
        ram_data = (state_q == ST_FLUSH) ? '0 : in_data;
        ram_addr = phase_q ? {col_q, row_q} : {row_q, col_q};
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q       <= '0;
            col_q       <= '0;
            phase_q     <= 1'b0;
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = ram_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_transpose_ctrl.sv
// Directed bench for transpose_ctrl with N=4, 8-bit elements and a behavioural read-before-write RAM.
module tb_transpose_ctrl;

    localparam int DW = 8;
    localparam int DL = 2;
    localparam int N  = 4;
    localparam int AW = 2 * DL;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    always #5 clk = ~clk;

    transpose_ctrl #(.DATA_WIDTH(DW), .DIM_LOG2(DL)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    // Single-port RAM: q returns the old word of the written address, and only on writes.
    logic [DW-1:0] mem [N*N];
    always @(posedge clk) begin
        if (ram_we) begin
            ram_q         <= mem[ram_addr];
            mem[ram_addr] <= ram_data;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int bad_bp;
    always @(posedge clk) cyc++;

    logic [8:0]  outq [$];   // {last, data}
    logic [12:0] wrq  [$];   // {in_ready, ram_data, ram_addr}

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) outq.push_back({out_last, out_data});
        if (!reset && ram_we) wrq.push_back({in_ready, ram_data, ram_addr});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] elem(input int tc, input int r, input int c);
        if (tc == 0) return 8'(16 * r + c);
        if (tc == 1) return 8'h00;
        return 8'((tc << 5) | (r << 2) | c);
    endfunction

    task automatic send_tile(input int tc, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) begin
            int b = 0;
            in_valid = 1'b1;
            in_data  = elem(tc, k / N, k % N);
            do begin
                @(negedge clk);
                b++;
            end while (!in_ready && b < 100);
            if (!in_ready) begin
                chk("send_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int n);
        int b = 0;
        while (outq.size() < n && b < 200) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk(tag, outq.size(), n);
    endtask

    // Output beat k at row-major (r,c) must be T[c][r] of the tile in question.
    task automatic check_tile(input string tag, input int tc);
        if (outq.size() < N * N) return;
        for (int k = 0; k < N * N; k++) begin
            logic [8:0] e;
            e = outq.pop_front();
            chk($sformatf("%s_d%0d", tag, k), e[7:0], elem(tc, k % N, k / N));
            chk($sformatf("%s_l%0d", tag, k), e[8], (k == N * N - 1));
        end
    endtask

    initial begin
        int t0;
        int bad;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N * N; i++) mem[i] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ram_we", ram_we, 0);
        reset = 1'b0;
        outq.delete();
        wrq.delete();

        // Tiles A, B, C back to back.
        t0 = cyc;
        send_tile(0, 0, 16);
        chk("a_no_out", outq.size(), 0);
        send_tile(1, 0, 16);
        send_tile(2, 0, 16);
        chk("abc_cycles", cyc - t0, 48);
        wait_out("abc_out_cnt", 32);
        check_tile("bt_a", 0);
        check_tile("ct_b", 2 - 1);
        chk("abc_wr_cnt", wrq.size(), 48);
        for (int i = 0; i < 48 && wrq.size() > 0; i++) begin
            logic [12:0] w;
            int k;
            int exp_a;
            w = wrq.pop_front();
            k = i % 16;
            exp_a = ((i / 16) == 1) ? ((k % N) * N + k / N) : k;
            chk($sformatf("addr_%0d", i), w[3:0], exp_a);
        end

        // Flush the stored tile C at the boundary.
        outq.delete();
        wrq.delete();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_in_ready", in_ready, 0);
        wait_out("fl_out_cnt", 16);
        check_tile("fl_c", 2);
        chk("fl_wr_cnt", wrq.size(), 16);
        bad = 0;
        for (int k = 0; k < 16 && wrq.size() > 0; k++) begin
            logic [12:0] w;
            w = wrq.pop_front();
            if (w[12] !== 1'b0 || w[11:4] !== 8'h00 || w[3:0] !== 4'((k % N) * N + k / N)) bad++;
        end
        chk("fl_wr_bad", bad, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("fl_done_ready", in_ready, 1);
        outq.delete();
        send_tile(3, 0, 16);
        repeat (3) @(posedge clk);
        #1;
        chk("d_no_out", outq.size(), 0);

        // Backpressure mid-tile while tile E streams in.
        outq.delete();
        bad_bp = 0;
        fork
            send_tile(4, 0, 16);
            begin
                logic [DW-1:0] ref_d;
                logic          ref_v;
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0) begin
                        ref_d = out_data;
                        ref_v = out_valid;
                    end
                    if (in_ready !== 1'b0 || ram_we !== 1'b0 || out_valid !== 1'b1 || out_data !== ref_d)
                        bad_bp++;
                end
                chk("bp_ref_valid", ref_v, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("bp_stall_bad", bad_bp, 0);
        wait_out("bp_out_cnt", 16);
        check_tile("bp_d", 3);

        // Reset after 7 beats of tile F.
        send_tile(5, 0, 7);
        chk("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        outq.delete();

        // flush in EMPTY is ignored.
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fe_in_ready", in_ready, 1);
        chk("fe_ram_we", ram_we, 0);
        send_tile(6, 0, 16);
        chk("g_no_out", outq.size(), 0);

        // flush mid-tile in STREAM is ignored.
        send_tile(7, 0, 5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fm_in_ready", in_ready, 1);
        chk("fm_ram_we", ram_we, 0);
        send_tile(7, 5, 11);
        wait_out("h_out_cnt", 16);
        check_tile("h_g", 6);
        repeat (3) @(posedge clk);
        #1;
        chk("h_no_extra", outq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
